// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder
// Receive side of a toggle-encoded event link. The incoming tog_in level is
// resynchronised, and every transition becomes a one-cycle evt_pulse. Events
// queue in a saturating pending counter and are handed downstream over a
// valid/ready handshake.
//
// Optional build macro TOGGLE_EVT_GLITCH_FILTER_EN: adds one filter stage
// behind the synchroniser. An edge is then accepted only after the last sync
// stage has held its new value for two consecutive cycles, which adds one
// cycle of latency.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,   // legal 2..4
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             tog_in,
    input  logic             ovf_clr,
    input  logic             evt_ready,
    output logic             evt_pulse,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // NOTE: the sync chain and the reference level are deliberately left out
    // of reset; they start at 0 from their declaration values and keep
    // tracking tog_in through reset, so no event appears on reset release.
    logic [SYNC_STAGES-1:0] sync_q = '0;
    logic                   ref_q  = 1'b0;
    logic                   ref_d;

    logic                   sync_lvl;    // last synchroniser stage
    logic                   filt_lvl;    // level seen by the edge detector
    logic                   edge_w;

    logic [CNT_W-1:0]       pending_q, pending_d;
    logic                   ovf_q, ovf_d;
    logic                   pulse_q;
    logic                   inc, dec;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Synchroniser shift register: tog_in enters stage 0 and moves one stage per clock.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every stage samples the value its
        // predecessor held before this edge.
        sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
    end

`ifdef TOGGLE_EVT_GLITCH_FILTER_EN
    // The extra stage remembers what the last sync stage held one cycle ago.
    logic hold_q = 1'b0;

    // Filter history register: a copy of the last sync stage, one cycle later.
    always_ff @(posedge clk) begin
        hold_q <= sync_lvl;
    end

    // A new level is taken only when it has been seen on two consecutive
    // cycles. Otherwise the previously accepted level is kept, so a one-cycle
    // excursion never reaches the edge detector.
    assign filt_lvl = (sync_lvl == hold_q) ? sync_lvl : ref_q;
`else
    assign filt_lvl = sync_lvl;
`endif

    assign level  = filt_lvl;
    assign edge_w = filt_lvl ^ ref_q;

    // The reference follows the detected level. During reset it loads the raw
    // last sync stage, so any edge already there is absorbed and lost.
    assign ref_d = clr_n ? filt_lvl : sync_lvl;

    // Reference-level register: runs every cycle, reset or not.
    always_ff @(posedge clk) begin
        ref_q <= ref_d;
    end

    assign inc = edge_w;
    assign dec = evt_valid && evt_ready;

    // Next-state logic for the pending counter and the sticky overflow flag.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no
        // latch is inferred.
        pending_d = pending_q;
        ovf_d     = ovf_q;

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        unique case ({inc, dec})
            2'b10: begin
                if (pending_q == CNT_MAX) begin
                    ovf_d = 1'b1;             // set beats a same-cycle clear
                end else begin
                    pending_d = pending_q + 1'b1;
                end
            end
            2'b01:   pending_d = pending_q - 1'b1;  // dec implies pending_q != 0
            default: pending_d = pending_q;         // both or neither: hold
        endcase
    end

    // Counter, overflow and event-pulse registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            pending_q <= '0;
            ovf_q     <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            pulse_q   <= edge_w;
        end
    end

    assign evt_pulse = pulse_q;
    assign evt_valid = (pending_q != '0);
    assign pending   = pending_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed self-checking bench for toggle_event_decoder (SYNC_STAGES=2, CNT_W=4).
// Build with +define+TOGGLE_EVT_GLITCH_FILTER_EN to exercise the filter.
module tb_toggle_event_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;
`ifdef TOGGLE_EVT_GLITCH_FILTER_EN
    localparam int LAT = SYNC_STAGES + 1;
`else
    localparam int LAT = SYNC_STAGES;
`endif

    logic             clk = 1'b0;
    logic             clr_n;
    logic             tog_in;
    logic             ovf_clr;
    logic             evt_ready;
    logic             evt_pulse;
    logic             evt_valid;
    logic [CNT_W-1:0] pending;
    logic             overflow;
    logic             level;

    int n_total = 0;
    int n_pass  = 0;

    toggle_event_decoder #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .tog_in   (tog_in),
        .ovf_clr  (ovf_clr),
        .evt_ready(evt_ready),
        .evt_pulse(evt_pulse),
        .evt_valid(evt_valid),
        .pending  (pending),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with tog_in static high: no spurious event on release.
        clr_n     = 1'b0;
        tog_in    = 1'b1;
        ovf_clr   = 1'b0;
        evt_ready = 1'b0;
        repeat (5) tick();
        check("rst_pulse",    evt_pulse, 0);
        check("rst_valid",    evt_valid, 0);
        check("rst_pending",  pending,   0);
        check("rst_overflow", overflow,  0);
        clr_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("static_no_pulse", evt_pulse, 0);
        end
        check("static_pending", pending,   0);
        check("static_valid",   evt_valid, 0);
        check("static_level",   level,     1);

        // Falling transition counts as an event too; drain it.
        tog_in = 1'b0;
        repeat (LAT + 2) tick();
        check("fall_pending", pending, 1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("fall_drain", pending, 0);

        // Rising transition: pulse exactly in the cycle after edge N+LAT.
        tog_in = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            tick();
            check("lat_no_pulse_yet", evt_pulse, 0);
            check("lat_no_pend_yet",  pending,   0);
        end
        tick();
        check("lat_pulse",   evt_pulse, 1);
        check("lat_pending", pending,   1);
        check("lat_valid",   evt_valid, 1);
        tick();
        check("lat_pulse_gone",  evt_pulse, 0);
        check("lat_pending_hold", pending,  1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("accept_pending", pending,   0);
        check("accept_valid",   evt_valid, 0);

        // Fill to max, then overflow, then clear the sticky flag.
        for (int k = 0; k < 15; k++) begin
            tog_in = ~tog_in;
            repeat (4) tick();
        end
        check("full_pending",  pending,  15);
        check("full_overflow", overflow, 0);
        tog_in = ~tog_in;
        repeat (4) tick();
        check("ovf_pending",  pending,  15);
        check("ovf_overflow", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared",       overflow, 0);
        check("ovf_clr_pending",   pending,  15);

        // At max, an arrival together with an accept holds the count, no overflow.
        tog_in = ~tog_in;
        repeat (LAT) tick();
        evt_ready = 1'b1;
        tick();
        check("max_incdec_pulse",   evt_pulse, 1);
        check("max_incdec_pending", pending,   15);
        check("max_incdec_ovf",     overflow,  0);
        repeat (14) tick();
        check("drain_one_left", pending, 1);
        tick();
        check("drain_empty",   pending,   0);
        check("drain_invalid", evt_valid, 0);
        repeat (2) tick();
        check("no_wrap_pending", pending,  0);
        check("no_wrap_ovf",     overflow, 0);
        evt_ready = 1'b0;

        // Reset while an edge is about to register: it is absorbed and lost.
        for (int k = 0; k < 6; k++) begin
            tog_in = ~tog_in;
            repeat (4) tick();
        end
        check("pre_rst_pending", pending, 6);
        tog_in = ~tog_in;
        repeat (LAT) tick();
        clr_n = 1'b0;
        tick();
        check("mid_rst_pending", pending,   0);
        check("mid_rst_ovf",     overflow,  0);
        check("mid_rst_pulse",   evt_pulse, 0);
        clr_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_no_pulse", evt_pulse, 0);
        end
        check("post_rst_pending", pending, 0);

`ifdef TOGGLE_EVT_GLITCH_FILTER_EN
        // One-cycle excursion is filtered out entirely.
        tog_in = ~tog_in;
        tick();
        tog_in = ~tog_in;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("glitch_no_pulse", evt_pulse, 0);
        end
        check("glitch_pending", pending, 0);
`else
        // Without the filter a one-cycle excursion is two real transitions.
        tog_in = ~tog_in;
        tick();
        tog_in = ~tog_in;
        repeat (LAT + 3) tick();
        check("short_pair_pending", pending, 2);
        evt_ready = 1'b1;
        repeat (2) tick();
        evt_ready = 1'b0;
        check("short_pair_drained", pending, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
